// File: rtl/if_pc_stage.sv
// Instruction-fetch PC stage: next-PC selection, trap redirection with EPC capture,
// and a synchronised, edge-latched external interrupt.
module if_pc_stage #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exception,
    input  logic        irq,
    output logic [31:0] pc_out,
    output logic [31:0] pc_add_4,
    output logic        trap_flush,
    output logic [31:0] epc
);

    logic        irq_s1;
    logic        irq_s2;
    logic        irq_s2_d;
    logic        irq_pending;
    logic        irq_edge;
    logic        take_exc;
    logic        take_irq;
    logic [31:0] pc_next;

    // Bit 31 is the kernel flag and never participates in the +4 carry.
    assign pc_add_4 = {pc_out[31], pc_out[30:0] + 31'd4};
    assign irq_edge = irq_s2 & ~irq_s2_d;

    always_comb begin
        take_exc = 1'b0;
        take_irq = 1'b0;
        pc_next  = pc_out;
        if (branch_taken) begin
            pc_next = {pc_out[31], branch_target[30:0]};
        end else if (exception) begin
            take_exc = 1'b1;
            pc_next  = ILLOP_VEC;
        end else if (irq_pending && !pc_out[31] && pc_write) begin
            take_irq = 1'b1;
            pc_next  = XADR_VEC;
        end else if (jr && pc_write) begin
            pc_next = {jr_target[31] & pc_out[31], jr_target[30:0]};
        end else if (jump && pc_write) begin
            pc_next = {pc_add_4[31:28], jump_target, 2'b00};
        end else if (pc_write) begin
            pc_next = pc_add_4;
        end
    end

    assign trap_flush = take_exc | take_irq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out      <= RESET_VEC;
            epc         <= '0;
            irq_s1      <= 1'b0;
            irq_s2      <= 1'b0;
            irq_s2_d    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            pc_out   <= pc_next;
            irq_s1   <= irq;
            irq_s2   <= irq_s1;
            irq_s2_d <= irq_s2;
            if (trap_flush)
                epc <= pc_out;
            // A fresh edge in the take cycle keeps the request pending.
            if (irq_edge)
                irq_pending <= 1'b1;
            else if (take_irq)
                irq_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_pc_stage.sv
// Randomised scoreboard bench for if_pc_stage against a behavioural next-PC model.
module tb_if_pc_stage;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC  = 32'h8000_0008;
    localparam int N_CYCLES = 4000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pc_write = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = '0;
    logic        exception = 1'b0;
    logic        irq = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] pc_add_4;
    logic        trap_flush;
    logic [31:0] epc;

    if_pc_stage #(.RESET_VEC(RESET_VEC), .ILLOP_VEC(ILLOP_VEC), .XADR_VEC(XADR_VEC)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .branch_taken(branch_taken),
        .branch_target(branch_target), .jump(jump), .jump_target(jump_target), .jr(jr),
        .jr_target(jr_target), .exception(exception), .irq(irq), .pc_out(pc_out),
        .pc_add_4(pc_add_4), .trap_flush(trap_flush), .epc(epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [31:0] pc;
        logic [31:0] epc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int traps_irq = 0;
    int traps_exc = 0;
    bit driving_done = 0;

    // Reference state: PC, EPC, pending flag and the irq samples seen at the last three edges.
    logic [31:0] m_pc, m_epc;
    logic        m_pend;
    logic [2:0]  m_hist;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] plus4(input logic [31:0] a);
        return (a & 32'h8000_0000) | ((a + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFC;
            1: return 32'h0040_0000 + ($urandom_range(0, 63) << 2);
            2: return 32'h8000_0100;
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = RESET_VEC; m_epc = '0; m_pend = 1'b0; m_hist = '0;
    endtask

    // Compute the response to the inputs currently driven, then advance the model by one edge.
    task automatic model_step(output exp_t e);
        logic [31:0] nxt, pa4;
        logic take_irq, trap, edge_seen;
        pa4 = plus4(m_pc);
        take_irq = 1'b0;
        trap = 1'b0;
        nxt = m_pc;
        if (branch_taken) nxt = (m_pc & 32'h8000_0000) | (branch_target & 32'h7FFF_FFFF);
        else if (exception) begin nxt = ILLOP_VEC; trap = 1'b1; traps_exc++; end
        else if (m_pend && !m_pc[31] && pc_write) begin
            nxt = XADR_VEC; trap = 1'b1; take_irq = 1'b1; traps_irq++;
        end
        else if (jr && pc_write) nxt = (jr_target & m_pc & 32'h8000_0000) | (jr_target & 32'h7FFF_FFFF);
        else if (jump && pc_write) nxt = (pa4 & 32'hF000_0000) | {4'b0, jump_target, 2'b00};
        else if (pc_write) nxt = pa4;
        edge_seen = m_hist[1] && !m_hist[2];
        e.flush = trap;
        if (trap) m_epc = m_pc;
        if (edge_seen) m_pend = 1'b1;
        else if (take_irq) m_pend = 1'b0;
        m_hist = {m_hist[1], m_hist[0], irq};
        m_pc = nxt;
        e.pc = m_pc;
        e.epc = m_epc;
    endtask

    initial begin : driver
        exp_t e;
        model_reset();
        repeat (3) @(negedge clk);
        check32("reset_pc", pc_out, RESET_VEC);
        check32("reset_epc", epc, 32'h0);
        check32("reset_flush", {31'b0, trap_flush}, 32'h0);
        reset = 1'b1;
        for (int c = 0; c < N_CYCLES; c++) begin
            @(negedge clk);
            if (c % 700 == 699) begin
                // Mid-run reset for one cycle with all requests idle.
                reset = 1'b0;
                pc_write = 0; branch_taken = 0; jump = 0; jr = 0; exception = 0;
                model_reset();
                #1;
                e.flush = 1'b0; e.pc = RESET_VEC; e.epc = '0;
                q.push_back(e);
                continue;
            end
            reset = 1'b1;
            pc_write      = ($urandom_range(0, 99) < 80);
            branch_taken  = ($urandom_range(0, 99) < 6);
            branch_target = pick_addr();
            exception     = ($urandom_range(0, 99) < 3);
            jr            = ($urandom_range(0, 99) < 12);
            jr_target     = ($urandom_range(0, 2) == 0) ? 32'h8000_0000 : pick_addr();
            jump          = ($urandom_range(0, 99) < 10);
            jump_target   = 26'($urandom);
            if ($urandom_range(0, 99) < 8) irq = ~irq;
            #1;
            model_step(e);
            q.push_back(e);
        end
        @(negedge clk);
        driving_done = 1;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                checks++;
                if (trap_flush !== q[0].flush) begin
                    errors++;
                    $display("FAIL trap_flush: actual=%0b required=%0b at %0t", trap_flush, q[0].flush, $time);
                end
            end
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check32("pc_out", pc_out, e.pc);
                check32("epc", epc, e.epc);
                check32("pc_add_4", pc_add_4, plus4(e.pc));
            end
        end
    end

    initial begin : finisher
        int budget;
        budget = 0;
        while (!driving_done && budget < N_CYCLES + 100) begin
            @(posedge clk);
            budget++;
        end
        repeat (3) @(posedge clk);
        checks++;
        if (!driving_done || q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending entries (done=%0b) required=0", q.size(), driving_done);
        end
        checks++;
        if (traps_irq == 0 || traps_exc == 0) begin
            errors++;
            $display("FAIL coverage: actual irq_traps=%0d exc_traps=%0d required both >0", traps_irq, traps_exc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
